// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter generator.
package pc_pkg;

    localparam int          DEFAULT_ADDR_W       = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;
    localparam int          DEFAULT_STEP         = 4;
    localparam int          DEFAULT_RAS_DEPTH    = 4;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_REDIR,
        SEL_MISALIGN,
        SEL_HOLD,
        SEL_RET,
        SEL_SEQ
    } pc_sel_t;

    // Sources that discard the instructions already in IF/ID.
    function automatic logic is_flush_src(input pc_sel_t sel);
        return (sel == SEL_EXC) || (sel == SEL_REDIR) || (sel == SEL_MISALIGN);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer whose oldest entry is overwritten when a push
// arrives while full; the count saturates at RAS_DEPTH.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int               PTR_W   = $clog2(RAS_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, wr_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_MAX);
    assign top   = mem_q[ptr_q];

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push && pop && !empty) begin
            // Pop-then-push collapses into rewriting the top slot in place.
            wr_en = 1'b1;
        end else if (push) begin
            ptr_d  = ptr_q + PTR_W'(1);
            wr_idx = ptr_q + PTR_W'(1);
            wr_en  = 1'b1;
            if (!full) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the storage array is not reset; a zero count makes its contents unobservable.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: prioritised next-PC select, exception/redirect
// flush pulses, EPC capture and call/return prediction through a return-address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR),
    parameter int                STEP         = DEFAULT_STEP,
    parameter int                RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc_valid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              call_push,
    input  logic              ret_pop,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus_step,
    output logic              flush,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] epc_out,
    output logic              ras_empty,
    output logic              ras_full
);

    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] ras_top;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;
    logic              ras_push, ras_pop, ras_clear;
    logic              target_aligned;

    assign pc_plus_step   = pc_q + ADDR_W'(STEP);
    assign target_aligned = (redirect_target % ADDR_W'(STEP)) == '0;

    // Exception and redirect win over stall; a return with nothing stacked falls through.
    always_comb begin
        sel = SEL_SEQ;
        if (exc_valid)                  sel = SEL_EXC;
        else if (redirect_valid)        sel = target_aligned ? SEL_REDIR : SEL_MISALIGN;
        else if (stall)                 sel = SEL_HOLD;
        else if (ret_pop && !ras_empty) sel = SEL_RET;
    end

    always_comb begin
        pc_d  = pc_plus_step;
        epc_d = epc_q;
        case (sel)
            SEL_EXC: begin
                pc_d  = EXC_VECTOR;
                epc_d = pc_q;
            end
            SEL_REDIR:    pc_d = redirect_target;
            SEL_MISALIGN: begin
                pc_d  = EXC_VECTOR;
                epc_d = redirect_target;
            end
            SEL_HOLD:     pc_d = pc_q;
            SEL_RET:      pc_d = ras_top;
            default:      pc_d = pc_plus_step;
        endcase

        flush_d    = is_flush_src(sel);
        misalign_d = (sel == SEL_MISALIGN);
        // The stack only moves when the fetch stream actually advances.
        ras_push   = call_push && ((sel == SEL_RET) || (sel == SEL_SEQ));
        ras_pop    = (sel == SEL_RET);
        ras_clear  = (sel == SEL_EXC) || (sel == SEL_MISALIGN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .clear (ras_clear),
        .din   (pc_plus_step),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign pc_out       = pc_q;
    assign epc_out      = epc_q;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic, checked against a
// queue-based reference model of the next-PC rules.
module tb_pc_gen;

    localparam logic [31:0] EXC_VEC = 32'h8000_0180;
    localparam int          DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, exc_valid = 1'b0, redirect_valid = 1'b0;
    logic        call_push = 1'b0, ret_pop = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_out, pc_plus_step, epc_out;
    logic        flush, misalign_err, ras_empty, ras_full;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .exc_valid       (exc_valid),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_push       (call_push),
        .ret_pop         (ret_pop),
        .pc_out          (pc_out),
        .pc_plus_step    (pc_plus_step),
        .flush           (flush),
        .misalign_err    (misalign_err),
        .epc_out         (epc_out),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pps;
        logic [31:0] epc;
        logic        flush;
        logic        mis;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;

    // Reference model state: the stack is a plain queue, newest entry at the back.
    logic [31:0] m_pc, m_epc;
    logic        m_flush, m_mis;
    logic [31:0] m_ras[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_flush = 1'b0; m_mis = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step(input logic s, input logic e, input logic rv,
                              input logic [31:0] rt, input logic cp, input logic rp);
        logic [31:0] pps;
        pps     = m_pc + 32'd4;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (e) begin
            m_epc = m_pc; m_pc = EXC_VEC; m_flush = 1'b1; m_ras.delete();
        end else if (rv && (rt % 4 == 0)) begin
            m_pc = rt; m_flush = 1'b1;
        end else if (rv) begin
            m_epc = rt; m_pc = EXC_VEC; m_flush = 1'b1; m_mis = 1'b1; m_ras.delete();
        end else if (!s) begin
            if (rp && m_ras.size() > 0) m_pc = m_ras.pop_back();
            else                        m_pc = pps;
            if (cp) begin
                m_ras.push_back(pps);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
    endtask

    // Apply inputs for the coming edge and queue what the model says must follow it.
    task automatic drive(input logic s, input logic e, input logic rv,
                         input logic [31:0] rt, input logic cp, input logic rp);
        exp_t x;
        stall = s; exc_valid = e; redirect_valid = rv; redirect_target = rt;
        call_push = cp; ret_pop = rp;
        model_step(s, e, rv, rt, cp, rp);
        x.pc    = m_pc;
        x.pps   = m_pc + 32'd4;
        x.epc   = m_epc;
        x.flush = m_flush;
        x.mis   = m_mis;
        x.empty = (m_ras.size() == 0);
        x.full  = (m_ras.size() == DEPTH);
        exp_q.push_back(x);
    endtask

    task automatic step(input logic s, input logic e, input logic rv,
                        input logic [31:0] rt, input logic cp, input logic rp);
        @(negedge clk);
        drive(s, e, rv, rt, cp, rp);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every edge out of reset consumes one expected response.
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_pc", pc_out, mon_e.pc);
            check("sb_pc_plus_step", pc_plus_step, mon_e.pps);
            check("sb_epc", epc_out, mon_e.epc);
            check("sb_flush", {31'b0, flush}, {31'b0, mon_e.flush});
            check("sb_misalign", {31'b0, misalign_err}, {31'b0, mon_e.mis});
            check("sb_ras_empty", {31'b0, ras_empty}, {31'b0, mon_e.empty});
            check("sb_ras_full", {31'b0, ras_full}, {31'b0, mon_e.full});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        logic [31:0] pops [4];
        pops[0] = 32'h44; pops[1] = 32'h34; pops[2] = 32'h24; pops[3] = 32'h14;

        // Power-on reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_ras_full", {31'b0, ras_full}, 32'h0);

        // 1: asynchronous reset mid-run, then sequential stepping.
        @(negedge clk); rst = 1'b0; drive(0, 0, 0, 32'h0, 1, 0);
        step(0, 0, 1, 32'h40, 0, 0);
        settle();
        check("t1_pc_40", pc_out, 32'h40);
        #2 rst = 1'b1;
        #1;
        check("t1_async_pc", pc_out, 32'h0);
        check("t1_async_ras_empty", {31'b0, ras_empty}, 32'h1);
        check("t1_async_flush", {31'b0, flush}, 32'h0);
        model_reset();
        @(negedge clk); rst = 1'b0; drive(0, 0, 0, 32'h0, 0, 0);
        settle(); check("t1_seq_4", pc_out, 32'h4);
        step(0, 0, 0, 32'h0, 0, 0);
        settle(); check("t1_seq_8", pc_out, 32'h8);
        step(0, 0, 0, 32'h0, 0, 0);
        settle(); check("t1_seq_c", pc_out, 32'hC);

        // 2: stall holds, redirect overrides stall.
        step(0, 0, 1, 32'h10, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        settle(); check("t2_hold_1", pc_out, 32'h10);
        step(1, 0, 0, 32'h0, 1, 0);
        settle(); check("t2_hold_2", pc_out, 32'h10);
        step(1, 0, 1, 32'h200, 0, 0);
        settle();
        check("t2_redir_pc", pc_out, 32'h200);
        check("t2_redir_flush", {31'b0, flush}, 32'h1);
        step(0, 0, 0, 32'h0, 0, 0);
        settle();
        check("t2_flush_drop", {31'b0, flush}, 32'h0);

        // 3: misaligned redirect clears a non-empty stack.
        step(0, 0, 1, 32'h2C, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        settle(); check("t3_ras_loaded", {31'b0, ras_empty}, 32'h0);
        step(0, 0, 1, 32'h102, 0, 0);
        settle();
        check("t3_mis_pc", pc_out, EXC_VEC);
        check("t3_mis_epc", epc_out, 32'h102);
        check("t3_mis_err", {31'b0, misalign_err}, 32'h1);
        check("t3_mis_flush", {31'b0, flush}, 32'h1);
        check("t3_mis_ras_empty", {31'b0, ras_empty}, 32'h1);
        step(0, 0, 0, 32'h0, 0, 0);
        settle();
        check("t3_err_drop", {31'b0, misalign_err}, 32'h0);

        // 4: call/return prediction, then return on an empty stack.
        step(0, 0, 1, 32'h100, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        step(0, 0, 1, 32'h400, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 1);
        settle(); check("t4_ret_404", pc_out, 32'h404);
        step(0, 0, 0, 32'h0, 0, 1);
        settle(); check("t4_ret_104", pc_out, 32'h104);
        step(0, 0, 0, 32'h0, 0, 1);
        settle();
        check("t4_ret_empty_seq", pc_out, 32'h108);
        check("t4_ras_empty", {31'b0, ras_empty}, 32'h1);

        // 5: overflow overwrites the oldest entry.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 32'(i * 16), 0, 0);
            step(0, 0, 0, 32'h0, 1, 0);
        end
        settle(); check("t5_ras_full", {31'b0, ras_full}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 32'h0, 0, 1);
            settle(); check("t5_pop", pc_out, pops[i]);
        end
        check("t5_ras_empty", {31'b0, ras_empty}, 32'h1);

        // 6: address wrap, then exception beating redirect and return.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        settle(); check("t6_pps_wrap", pc_plus_step, 32'h0);
        step(0, 0, 0, 32'h0, 0, 0);
        settle(); check("t6_pc_wrap", pc_out, 32'h0);
        step(0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        settle(); check("t6_pc_8", pc_out, 32'h8);
        step(0, 1, 1, 32'h300, 0, 1);
        settle();
        check("t6_exc_pc", pc_out, EXC_VEC);
        check("t6_exc_epc", epc_out, 32'h8);
        check("t6_exc_ras_empty", {31'b0, ras_empty}, 32'h1);
        check("t6_exc_flush", {31'b0, flush}, 32'h1);
        step(0, 0, 0, 32'h0, 0, 0);
        settle(); check("t6_flush_drop", {31'b0, flush}, 32'h0);

        // Random traffic, mostly aligned targets, occasional exceptions.
        repeat (400) begin
            t = $urandom();
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step($urandom_range(5) == 0, $urandom_range(31) == 0, $urandom_range(7) == 0,
                 t, $urandom_range(3) == 0, $urandom_range(3) == 0);
        end
        step(0, 0, 0, 32'h0, 0, 0);
        settle();
        #2;
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the MIPS pipeline fetch stage. It replaces the fixed 32-bit PC register with a unit that does the following:
- selects the next PC from exception, branch/jump redirect, return-address prediction, hold or sequential sources;
- raises a one-cycle flush toward IF/ID;
- keeps a small return-address stack (RAS) for call/return prediction.

Parameters:
ADDR_W, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h8000_0180, PC loaded on exception or misaligned redirect.
STEP, 4, sequential increment in bytes.
RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-high reset
stall  input  1  hold PC (hazard unit)
exc_valid  input  1  exception request
redirect_valid  input  1  resolved branch/jump taken (EX stage)
redirect_target  input  ADDR_W  redirect destination
call_push  input  1  fetched instruction is a call (jal/jalr)
ret_pop  input  1  fetched instruction is a return (jr $ra)
pc_out  output  ADDR_W  current fetch PC (registered)
pc_plus_step  output  ADDR_W  pc_out+STEP, combinational, wraps mod 2^ADDR_W
flush  output  1  one-cycle pulse after exception/redirect accepted
misalign_err  output  1  one-cycle pulse after misaligned redirect
epc_out  output  ADDR_W  PC of last exception / faulting target
ras_empty  output  1  RAS count == 0
ras_full  output  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc_out=RESET_VECTOR; flush=0; misalign_err=0; epc_out=0; RAS count=0 (ras_empty=1, ras_full=0).
  - First update occurs on the first rising edge after rst deasserts.
- Next-PC priority, evaluated each rising edge, highest first:
  1. exc_valid: pc<=EXC_VECTOR; epc<=pc_out; RAS cleared; flush<=1.
  2. redirect_valid, target aligned (target mod STEP == 0): pc<=redirect_target; flush<=1; RAS unchanged.
  3. redirect_valid, target misaligned: pc<=EXC_VECTOR; epc<=redirect_target; misalign_err<=1; flush<=1; RAS cleared.
  4. stall: pc held; RAS push/pop suppressed.
  5. ret_pop with RAS non-empty: pc<=top entry; pop (count-1). With RAS empty: treated as sequential.
  6. Otherwise sequential: pc<=pc_out+STEP, wrapping at 2^ADDR_W.
- flush and misalign_err are registered and high exactly one cycle per accepted event. Back-to-back events give back-to-back pulses.
- Exception and redirect override stall.
- RAS push:
  - Pushed value is pc_plus_step; push occurs only when call_push=1 and the PC source is 5 or 6.
  - Full RAS: the oldest entry is overwritten (circular buffer) and count stays RAS_DEPTH.
- Simultaneous call_push and ret_pop with RAS non-empty:
  - pc<=top entry, and top is replaced by pc_plus_step; count unchanged.
  - With RAS empty: push only, PC sequential.
- Latency: pc_out reflects all inputs one edge later. No combinational path from inputs to pc_out, flush or misalign_err.

Decomposition:
- Shared package pc_pkg:
  - next-PC source select enum SEL_EXC, SEL_REDIR, SEL_MISALIGN, SEL_HOLD, SEL_RET, SEL_SEQ;
  - default vector constants.
- One sub-module, ras_stack, parametrised by ADDR_W and RAS_DEPTH:
  - inputs push, pop, clear, din;
  - outputs top, empty, full;
  - same clk/rst convention;
  - owns the circular pointer and saturating count.
- pc_gen holds the priority select, the PC/EPC registers and the pulse registers.

Test Plan:
1. Reset: assert rst mid-run with pc_out=0x40 -> pc_out=0x0 immediately, without waiting for a clock edge; ras_empty=1. Release rst, then 3 edges with no inputs -> pc_out steps 0x4, 0x8, 0xC.
2. Stall vs redirect: at pc_out=0x10, stall=1 for 2 edges -> pc stays 0x10. Then stall=1 with redirect_valid=1, target 0x200 -> next pc_out=0x200, flush=1 for exactly one cycle.
3. Misaligned redirect at pc_out=0x30, target 0x102 -> pc_out=0x80000180, epc_out=0x102, misalign_err=1 and flush=1 for one cycle each, RAS cleared.
4. RAS basic: call_push at pc_out=0x100, then at 0x400 -> 2 entries. ret_pop -> pc_out=0x404; ret_pop -> 0x104; ret_pop with RAS empty -> sequential 0x108.
5. RAS overflow with RAS_DEPTH=4: 5 pushes at 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_full=1. 4 pops return 0x44, 0x34, 0x24, 0x14, then ras_empty=1.
6. Exception plus wrap:
   - pc_out=0xFFFFFFFC sequential -> 0x0.
   - exc_valid with redirect_valid and ret_pop all asserted at pc_out=0x8 -> pc_out=0x80000180, epc_out=0x8, RAS empty, flush one cycle.
